// File: rtl/div_unit_pkg.sv
// Shared constants, state encoding and helpers for the radix-2 divider.
package div_unit_pkg;

  localparam int XLEN      = 64;
  localparam int W32_ITERS = 32;
  localparam int QUO_LSB   = 0;
  localparam int REM_LSB   = 64;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v,
                                             input logic n);
    return n ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring iteration: shift {rem,quo} left, subtract, keep or restore.
module div_step
  import div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dmag_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   sh;
  logic [XLEN+1:0] diff;

  always_comb begin
    sh    = {rem_i, quo_i[XLEN-1]};
    diff  = {1'b0, sh} - {2'b00, dmag_i};
    quo_o = {quo_i[XLEN-2:0], ~diff[XLEN+1]};
    rem_o = diff[XLEN+1] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage (div/rem, W forms).
// Optional DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              div_valid,
  input  logic              div_32,
  input  logic              div_signed,
  input  logic              div_flush,
  input  logic [XLEN-1:0]   dividend,
  input  logic [XLEN-1:0]   divisor,
  output logic              div_ready,
  output logic [2*XLEN-1:0] div_result,
  output logic              div_busy
);

  localparam logic [5:0] CNT_X = 6'(XLEN - 1);
  localparam logic [5:0] CNT_W = 6'(W32_ITERS - 1);

  div_state_e state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dmag_q, dmag_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              w32_q, w32_d;
  logic [2*XLEN-1:0] res_q, res_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;
  logic [XLEN-1:0] sp_q, sp_r, rem_n, quo_n, fq, fr;
  logic            a_neg, b_neg, dz, ovf, early;

  div_step u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dmag_i (dmag_q),
    .rem_o  (rem_n),
    .quo_o  (quo_n)
  );

  always_comb begin
    a_ext = dividend;
    b_ext = divisor;
    if (div_32) begin
      a_ext = div_signed ? sext32(dividend) : {32'b0, dividend[31:0]};
      b_ext = div_signed ? sext32(divisor) : {32'b0, divisor[31:0]};
    end
    a_neg   = div_signed & a_ext[XLEN-1];
    b_neg   = div_signed & b_ext[XLEN-1];
    a_mag   = neg_if(a_ext, a_neg);
    b_mag   = neg_if(b_ext, b_neg);
    min_neg = div_32 ? {{33{1'b1}}, 31'b0} : {1'b1, 63'b0};
    dz      = (b_ext == '0);
    ovf     = div_signed & (&b_ext) & (a_ext == min_neg);
`ifdef DIV_EARLY_OUT_EN
    early   = ~dz & (a_mag < b_mag);
`else
    early   = 1'b0;
`endif
    sp_q = '0;
    sp_r = a_ext;
    if (dz) begin
      sp_q = '1;
    end else if (ovf) begin
      sp_q = a_ext;
      sp_r = '0;
    end
    if (div_32) begin
      sp_q = sext32(sp_q);
      sp_r = sext32(sp_r);
    end
    fq = neg_if(quo_n, qneg_q);
    fr = neg_if(rem_n, rneg_q);
    if (w32_q) begin
      fq = sext32(fq);
      fr = sext32(fr);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    w32_d   = w32_q;
    res_d   = res_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (div_valid) begin
          w32_d  = div_32;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          busy_d = 1'b1;
          if (dz | ovf | early) begin
            res_d[REM_LSB +: XLEN] = sp_r;
            res_d[QUO_LSB +: XLEN] = sp_q;
            ready_d = 1'b1;
            state_d = DIV_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = div_32 ? {a_mag[31:0], 32'b0} : a_mag;
            dmag_d  = b_mag;
            cnt_d   = div_32 ? CNT_W : CNT_X;
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        rem_d = rem_n;
        quo_d = quo_n;
        if (cnt_q == '0) begin
          res_d[REM_LSB +: XLEN] = fr;
          res_d[QUO_LSB +: XLEN] = fq;
          ready_d = 1'b1;
          state_d = DIV_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DIV_DONE: begin
        busy_d  = 1'b0;
        state_d = DIV_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = DIV_IDLE;
      end
    endcase
    // Flush discards the operation without committing its result.
    if (div_flush) begin
      state_d = DIV_IDLE;
      res_d   = res_q;
      ready_d = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      w32_q   <= 1'b0;
      res_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      w32_q   <= w32_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign div_ready  = ready_q;
  assign div_busy   = busy_q;
  assign div_result = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         div_valid;
  logic         div_32;
  logic         div_signed;
  logic         div_flush;
  logic [63:0]  dividend;
  logic [63:0]  divisor;
  logic         div_ready;
  logic [127:0] div_result;
  logic         div_busy;

  int tests = 0;
  int fails = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 65;
`endif

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .div_valid  (div_valid),
    .div_32     (div_32),
    .div_signed (div_signed),
    .div_flush  (div_flush),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_ready  (div_ready),
    .div_result (div_result),
    .div_busy   (div_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (div_busy !== 1'b1) busy_ok = 1'b0;
    end while (div_ready !== 1'b1 && lat < 200);
    if (div_ready !== 1'b1) lat = -1;
  endtask

  task automatic run_div(input string tag, input logic [63:0] a,
                         input logic [63:0] b, input bit w, input bit s,
                         input logic [63:0] eq, input logic [63:0] er,
                         input int elat);
    int lat;
    bit bok;
    dividend   = a;
    divisor    = b;
    div_32     = w;
    div_signed = s;
    div_valid  = 1'b1;
    wait_ready(lat, bok);
    div_valid = 1'b0;
    chk({tag, " latency"}, 128'(lat), 128'(elat));
    chk({tag, " busy"}, 128'(bok), 128'(1));
    chk({tag, " quo"}, 128'(div_result[63:0]), 128'(eq));
    chk({tag, " rem"}, 128'(div_result[127:64]), 128'(er));
    @(posedge clk);
    #1;
    chk({tag, " one-pulse"}, 128'(div_ready), 128'(0));
    chk({tag, " idle"}, 128'(div_busy), 128'(0));
    chk({tag, " held"}, div_result, {er, eq});
  endtask

  initial begin
    int lat;
    int nr;
    bit bok;
    rst        = 1'b1;
    div_valid  = 1'b0;
    div_32     = 1'b0;
    div_signed = 1'b0;
    div_flush  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 128'(div_ready), 128'(0));
    chk("reset busy", 128'(div_busy), 128'(0));
    chk("reset result", div_result, 128'(0));
    rst = 1'b0;

    run_div("s100_7", 64'd100, 64'd7, 0, 1, 64'd14, 64'd2, 65);
    run_div("sm100_7", 64'hFFFFFFFFFFFFFF9C, 64'd7, 0, 1,
            64'hFFFFFFFFFFFFFFF2, 64'hFFFFFFFFFFFFFFFE, 65);
    run_div("divw_ovf", 64'h0000000180000000, 64'hFFFFFFFFFFFFFFFF, 1, 1,
            64'hFFFFFFFF80000000, 64'h0, 1);
    run_div("div0", 64'd5, 64'd0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 64'd5, 1);
    run_div("divw_m7_2", 64'h00000000FFFFFFF9, 64'd2, 1, 1,
            64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 33);
    run_div("divu_big", 64'hFFFFFFFFFFFFFFFF, 64'd16, 0, 0,
            64'h0FFFFFFFFFFFFFFF, 64'hF, 65);
    run_div("ovf64", 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 0, 1,
            64'h8000000000000000, 64'h0, 1);
    run_div("divuw0", 64'h0000000080000005, 64'h0000000100000000, 1, 0,
            64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000005, 1);
    run_div("small", 64'd3, 64'd10, 0, 1, 64'd0, 64'd3, EO_LAT);

    dividend   = 64'd100;
    divisor    = 64'd7;
    div_32     = 1'b0;
    div_signed = 1'b1;
    div_valid  = 1'b1;
    nr         = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (div_ready === 1'b1) nr++;
    end
    chk("flush pre busy", 128'(div_busy), 128'(1));
    div_flush = 1'b1;
    @(posedge clk);
    #1;
    if (div_ready === 1'b1) nr++;
    chk("flush busy", 128'(div_busy), 128'(0));
    chk("flush no ready", 128'(nr), 128'(0));
    div_flush = 1'b0;
    dividend  = 64'd7;
    divisor   = 64'd2;
    wait_ready(lat, bok);
    div_valid = 1'b0;
    chk("after flush latency", 128'(lat), 128'(65));
    chk("after flush result", div_result, {64'd1, 64'd3});
    @(posedge clk);
    #1;

    dividend  = 64'd100;
    divisor   = 64'd7;
    div_valid = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst ready", 128'(div_ready), 128'(0));
    chk("arst busy", 128'(div_busy), 128'(0));
    chk("arst result", div_result, 128'(0));
    div_valid = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst idle", 128'(div_busy), 128'(0));

    dividend   = 64'd20;
    divisor    = 64'd3;
    div_signed = 1'b1;
    div_valid  = 1'b1;
    wait_ready(lat, bok);
    chk("b2b first latency", 128'(lat), 128'(65));
    chk("b2b first result", div_result, {64'd2, 64'd6});
    dividend = 64'd9;
    divisor  = 64'd4;
    wait_ready(lat, bok);
    div_valid = 1'b0;
    chk("b2b second latency", 128'(lat), 128'(66));
    chk("b2b second result", div_result, {64'd1, 64'd2});
    @(posedge clk);
    #1;
    chk("b2b one-pulse", 128'(div_ready), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider serving the EX stage's divide handshake.
- Accepts operands when div_valid is high in IDLE and iterates one quotient bit per cycle.
- Returns quotient and remainder packed on div_result with a one-cycle div_ready pulse.
- EX holds div_valid and stalls the pipeline until it sees div_ready.

Parameters:
- XLEN, 64, operand width; div_result is 2*XLEN.
- W32_ITERS, 32, iteration count for 32-bit (W) operations.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- div_valid  input  1  request; held high by EX until div_ready
- div_32  input  1  W-form operation (divw/remw); uses the low 32 bits of the operands
- div_signed  input  1  signed operands (1 for div/rem/divw/remw)
- div_flush  input  1  cancel any in-flight operation
- dividend  input  XLEN  forwarded rs1 value
- divisor  input  XLEN  forwarded rs2 value
- div_ready  output  1  one-cycle pulse; result valid
- div_result  output  2*XLEN  {remainder[127:64], quotient[63:0]}
- div_busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (async, rst=1): state IDLE; div_ready=0; div_busy=0; div_result=0; all internal registers cleared. Reset mid-operation aborts the operation immediately.
- States: IDLE, BUSY, DONE.
- IDLE:
  - div_valid=1 and div_flush=0: latch operand magnitudes, operand signs, div_32 and div_signed; go to BUSY (cycle 0).
  - Special cases resolve directly to DONE.
  - Otherwise remain in IDLE.
- W form: operands are the low 32 bits, sign-extended when div_signed=1, else zero-extended. Iteration count is W32_ITERS instead of XLEN.
- BUSY: one restoring step per cycle.
  - Shift {rem,quo} left by 1; trial = rem - divisor magnitude.
  - trial is non-negative: rem=trial, quo LSB=1; otherwise quo LSB=0.
  - The iteration counter counts down; at 0, apply the sign fix and register div_result, then go to DONE.
  - Signed sign fix: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- DONE: div_ready=1 for exactly this cycle; div_valid is ignored; next state IDLE. EX advances on this pulse, so div_valid seen in the following IDLE cycle is a new request (back-to-back divides are legal).
- Latency: ready in cycle N+1 after acceptance (N=64, or 32 for W), i.e. 66 or 34 cycles of stall including acceptance. Special cases: ready in cycle 1.
- Special cases, detected in IDLE:
  - Divisor == 0: quotient = all ones (XLEN bits), remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
  - W form: special-case results are sign-extended 32-bit values in [31:0] and [95:64].
- W-form outputs: quotient sign-extended in [63:0]; remainder sign-extended in [127:64].
- div_result holds its value until the next completion.
- div_flush: any state goes to IDLE next cycle, with no div_ready. Flush wins over a simultaneous div_valid in IDLE. Flush in DONE still lets the ready pulse occur that cycle, but the ready must be ignored by EX.
- div_valid dropping in BUSY (without flush) is a protocol violation; the operation completes normally.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |dividend| < |divisor| (non-zero divisor), go to DONE with quotient=0 and remainder=dividend; ready in cycle 1.
- Undefined: this case runs the full N iterations.
- Results are bit-identical either way; only latency differs.

Decomposition:
- Shared package/defines (alongside REG_BUS): XLEN, state encodings DIV_IDLE/DIV_BUSY/DIV_DONE, div_result field offsets (QUO_LSB=0, REM_LSB=64).
- One sub-module, div_step: combinational single restoring iteration; inputs {rem,quo} and divisor magnitude, outputs the next {rem,quo}.

Test Plan:
- 64-bit signed 100 / 7 -> div_ready in cycle 65 after acceptance; quotient 14, remainder 2; div_busy high throughout.
- 64-bit signed -100 / 7 -> quotient 0xFFFFFFFFFFFFFFF2, remainder 0xFFFFFFFFFFFFFFFE.
- divw with dividend=0x0000000180000000, divisor=0xFFFFFFFFFFFFFFFF -> overflow case: ready in cycle 1; [63:0]=0xFFFFFFFF80000000, [127:64]=0.
- 64-bit 5 / 0 -> ready in cycle 1; quotient 0xFFFFFFFFFFFFFFFF, remainder 5.
- Flush at BUSY cycle 10, then a new request 7/2 next cycle -> no ready for the first operation; second returns quotient 3, remainder 1 at cycle 65.
- Async rst asserted mid-BUSY between clock edges -> div_ready=0, div_busy=0, div_result=0 immediately; back-to-back 20/3 then 9/4 with div_valid held high -> two ready pulses with (6,2) and (2,1).
